param_stream_tx: RTL and testbench

Readback serializer for the network parameter set. On a start request it snapshots the six parameter arrays (W1, b1, W2, b2, W3, b3) currently driven by the input mux. It then streams them word-by-word over an AXI4-Stream master toward the PS/DMA. It is the reader counterpart of the parameter load/mux path: the host writes initial parameters in, this block sends initial or updated parameters back out.

---
 rtl/param_stream_tx_pkg.sv | 58 +++++
 rtl/param_tx_addr_gen.sv | 82 ++++++++
 rtl/param_stream_tx.sv | 180 ++++++++++++++++++
 tb/tb_param_stream_tx.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/param_stream_tx_pkg.sv
// Shared sizes, types and enums for the parameter readback serializer.
// Layer sizes here are the defaults picked up by param_stream_tx.
package param_stream_tx_pkg;

    localparam int L1 = 2;
    localparam int L2 = 3;
    localparam int L3 = 3;
    localparam int L4 = 1;

    localparam int DATA_W = 32;
    typedef logic [DATA_W-1:0] data_type;

    function automatic int param_words(
        input int a,
        input int b,
        input int c,
        input int d
    );
        return b*a + b + c*b + c + d*c + d;
    endfunction

    // Width needed to hold any row or column index of the four layers.
    function automatic int rc_width(
        input int a,
        input int b,
        input int c,
        input int d
    );
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int PARAM_WORDS = param_words(L1, L2, L3, L4);

    localparam logic [7:0] HDR_MAGIC = 8'hA5;

    typedef enum logic [2:0] {
        SEG_W1,
        SEG_B1,
        SEG_W2,
        SEG_B2,
        SEG_W3,
        SEG_B3
    } seg_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HDR,
        ST_SEND,
        ST_DONE
    } state_e;

endpackage

// File: rtl/param_tx_addr_gen.sv
// Walks the flat stream index and tracks segment/row/col coordinates.
// Returns to the origin after the final word so the next transfer starts clean.
module param_tx_addr_gen
    import param_stream_tx_pkg::*;
#(
    parameter int L1   = param_stream_tx_pkg::L1,
    parameter int L2   = param_stream_tx_pkg::L2,
    parameter int L3   = param_stream_tx_pkg::L3,
    parameter int L4   = param_stream_tx_pkg::L4,
    parameter int RC_W = rc_width(L1, L2, L3, L4)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            advance,
    output seg_e            segment,
    output logic [RC_W-1:0] row,
    output logic [RC_W-1:0] col,
    output logic            last
);

    localparam int N     = param_words(L1, L2, L3, L4);
    localparam int IDX_W = $clog2(N + 1);

    logic [IDX_W-1:0] idx;
    logic [RC_W-1:0]  row_max;
    logic [RC_W-1:0]  col_max;

    always_comb begin
        row_max = '0;
        col_max = '0;
        unique case (segment)
            SEG_W1: begin
                row_max = RC_W'(L2 - 1);
                col_max = RC_W'(L1 - 1);
            end
            SEG_B1: row_max = RC_W'(L2 - 1);
            SEG_W2: begin
                row_max = RC_W'(L3 - 1);
                col_max = RC_W'(L2 - 1);
            end
            SEG_B2: row_max = RC_W'(L3 - 1);
            SEG_W3: begin
                row_max = RC_W'(L4 - 1);
                col_max = RC_W'(L3 - 1);
            end
            SEG_B3: row_max = RC_W'(L4 - 1);
            default: ;
        endcase
    end

    assign last = (idx == IDX_W'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx     <= '0;
            segment <= SEG_W1;
            row     <= '0;
            col     <= '0;
        end else if (advance) begin
            if (last) begin
                idx     <= '0;
                segment <= SEG_W1;
                row     <= '0;
                col     <= '0;
            end else begin
                idx <= idx + 1'b1;
                if (col == col_max) begin
                    col <= '0;
                    if (row == row_max) begin
                        row     <= '0;
                        segment <= seg_e'(segment + 3'd1);
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/param_stream_tx.sv
// Snapshots W1..b3 on start and streams them out over AXI4-Stream.
// Optional leading header word: define PARAM_TX_HEADER_EN.
module param_stream_tx
    import param_stream_tx_pkg::*;
#(
    parameter int L1     = param_stream_tx_pkg::L1,
    parameter int L2     = param_stream_tx_pkg::L2,
    parameter int L3     = param_stream_tx_pkg::L3,
    parameter int L4     = param_stream_tx_pkg::L4,
    parameter int DATA_W = param_stream_tx_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [DATA_W-1:0] W1 [0:L2-1][0:L1-1],
    input  logic [DATA_W-1:0] W2 [0:L3-1][0:L2-1],
    input  logic [DATA_W-1:0] W3 [0:L4-1][0:L3-1],
    input  logic [DATA_W-1:0] b1 [0:L2-1][0:0],
    input  logic [DATA_W-1:0] b2 [0:L3-1][0:0],
    input  logic [DATA_W-1:0] b3 [0:L4-1][0:0],
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast
);

    localparam int N    = param_words(L1, L2, L3, L4);
    localparam int RC_W = rc_width(L1, L2, L3, L4);

    state_e state_q;
    state_e state_d;

    seg_e            segment;
    logic [RC_W-1:0] row;
    logic [RC_W-1:0] col;
    logic            last;
    logic            advance;
    logic [DATA_W-1:0] word;

    logic [DATA_W-1:0] w1_q [0:L2-1][0:L1-1];
    logic [DATA_W-1:0] w2_q [0:L3-1][0:L2-1];
    logic [DATA_W-1:0] w3_q [0:L4-1][0:L3-1];
    logic [DATA_W-1:0] b1_q [0:L2-1][0:0];
    logic [DATA_W-1:0] b2_q [0:L3-1][0:0];
    logic [DATA_W-1:0] b3_q [0:L4-1][0:0];

`ifdef PARAM_TX_HEADER_EN
    logic [DATA_W-1:0] hdr_word;

    always_comb begin
        hdr_word                = '0;
        hdr_word[DATA_W-1 -: 8] = HDR_MAGIC;
        hdr_word[15:0]          = 16'(N);
    end
`endif

    param_tx_addr_gen #(
        .L1   (L1),
        .L2   (L2),
        .L3   (L3),
        .L4   (L4),
        .RC_W (RC_W)
    ) u_addr (
        .clk     (clk),
        .reset   (reset),
        .advance (advance),
        .segment (segment),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
`ifdef PARAM_TX_HEADER_EN
            ST_LOAD: state_d = ST_HDR;
`else
            ST_LOAD: state_d = ST_SEND;
`endif
            ST_HDR:  if (m_axis_tready) state_d = ST_SEND;
            ST_SEND: if (m_axis_tready && last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        done          = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        advance       = 1'b0;
        unique case (state_q)
            ST_LOAD: busy = 1'b1;
            ST_HDR: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
`ifdef PARAM_TX_HEADER_EN
                m_axis_tdata  = hdr_word;
`endif
            end
            ST_SEND: begin
                busy          = 1'b1;
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = word;
                m_axis_tlast  = last;
                advance       = m_axis_tready;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Shadow copy decouples the stream from later input mux changes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w1_q <= '{default: '0};
            w2_q <= '{default: '0};
            w3_q <= '{default: '0};
            b1_q <= '{default: '0};
            b2_q <= '{default: '0};
            b3_q <= '{default: '0};
        end else if (state_q == ST_LOAD) begin
            w1_q <= W1;
            w2_q <= W2;
            w3_q <= W3;
            b1_q <= b1;
            b2_q <= b2;
            b3_q <= b3;
        end
    end

    always_comb begin
        word = '0;
        unique case (segment)
            SEG_W1:
                for (int r = 0; r < L2; r++)
                    for (int c = 0; c < L1; c++)
                        if (row == RC_W'(r) && col == RC_W'(c))
                            word = w1_q[r][c];
            SEG_B1:
                for (int r = 0; r < L2; r++)
                    if (row == RC_W'(r))
                        word = b1_q[r][0];
            SEG_W2:
                for (int r = 0; r < L3; r++)
                    for (int c = 0; c < L2; c++)
                        if (row == RC_W'(r) && col == RC_W'(c))
                            word = w2_q[r][c];
            SEG_B2:
                for (int r = 0; r < L3; r++)
                    if (row == RC_W'(r))
                        word = b2_q[r][0];
            SEG_W3:
                for (int r = 0; r < L4; r++)
                    for (int c = 0; c < L3; c++)
                        if (row == RC_W'(r) && col == RC_W'(c))
                            word = w3_q[r][c];
            SEG_B3:
                for (int r = 0; r < L4; r++)
                    if (row == RC_W'(r))
                        word = b3_q[r][0];
            default: ;
        endcase
    end

endmodule

// File: tb/tb_param_stream_tx.sv
// Directed bench for param_stream_tx with L1=2, L2=3, L3=3, L4=1 (25 words).
// Element values are {segment, flat index}; expected stream built locally.
module tb_param_stream_tx;

    localparam int N = 25;
`ifdef PARAM_TX_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif
    localparam int TOT = N + H;

    logic        clk;
    logic        reset;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] W1 [0:2][0:1];
    logic [31:0] W2 [0:2][0:2];
    logic [31:0] W3 [0:0][0:2];
    logic [31:0] b1 [0:2][0:0];
    logic [31:0] b2 [0:2][0:0];
    logic [31:0] b3 [0:0][0:0];
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;

    int total = 0;
    int bad   = 0;

    param_stream_tx dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .W1            (W1),
        .W2            (W2),
        .W3            (W3),
        .b1            (b1),
        .b2            (b2),
        .b3            (b3),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expw(input int k);
        int p;
        int s;
`ifdef PARAM_TX_HEADER_EN
        if (k == 0) return 32'hA500_0019;
        p = k - 1;
`else
        p = k;
`endif
        if (p < 6)       s = 0;
        else if (p < 9)  s = 1;
        else if (p < 18) s = 2;
        else if (p < 21) s = 3;
        else if (p < 24) s = 4;
        else             s = 5;
        return 32'((s << 8) | p);
    endfunction

    function automatic logic [31:0] mk(input int s, input int f, input bit inv);
        logic [31:0] v;
        v = 32'((s << 8) | f);
        return inv ? ~v : v;
    endfunction

    task automatic fill(input bit inv);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 2; c++)
                W1[r][c] = mk(0, r*2 + c, inv);
        for (int r = 0; r < 3; r++) b1[r][0] = mk(1, 6 + r, inv);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                W2[r][c] = mk(2, 9 + r*3 + c, inv);
        for (int r = 0; r < 3; r++) b2[r][0] = mk(3, 18 + r, inv);
        for (int c = 0; c < 3; c++) W3[0][c] = mk(4, 21 + c, inv);
        b3[0][0] = mk(5, 24, inv);
    endtask

    // Collects TOT words; returns at the cycle after the final handshake.
    task automatic recv(input bit rnd, input int budget);
        int          n = 0;
        int          cyc = 0;
        bit          holding = 0;
        logic [31:0] held = '0;
        while (n < TOT && cyc < budget) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (holding) begin
                check("hold_tvalid", 32'(m_axis_tvalid), 32'd1);
                check("hold_tdata", m_axis_tdata, held);
                holding = 0;
            end
            if (m_axis_tvalid) begin
                if (m_axis_tready) begin
                    check("word", m_axis_tdata, expw(n));
                    check("tlast", 32'(m_axis_tlast), 32'(n == TOT - 1));
                    n++;
                end else begin
                    holding = 1;
                    held    = m_axis_tdata;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (n < TOT) check("recv_timeout", 32'(n), 32'(TOT));
    endtask

    initial begin
        reset         = 1'b0;
        start         = 1'b0;
        m_axis_tready = 1'b0;
        fill(0);
        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast",  32'(m_axis_tlast), 32'd0);
        check("rst_tdata",  m_axis_tdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // full-rate transfer with exact cycle timing
        start         = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("load_busy",   32'(busy), 32'd1);
        check("load_tvalid", 32'(m_axis_tvalid), 32'd0);
        for (int k = 0; k < TOT; k++) begin
            @(negedge clk);
            check("fr_tvalid", 32'(m_axis_tvalid), 32'd1);
            check("fr_tdata",  m_axis_tdata, expw(k));
            check("fr_tlast",  32'(m_axis_tlast), 32'(k == TOT - 1));
        end
        @(negedge clk);
        check("fr_done",   32'(done), 32'd1);
        check("fr_busy",   32'(busy), 32'd0);
        check("fr_tvalid0", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("fr_done_pulse", 32'(done), 32'd0);

        // random backpressure
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recv(1, 400);
        check("bp_done", 32'(done), 32'd1);
        @(negedge clk);

        // inputs change after the snapshot edge
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        fill(1);
        recv(0, 100);
        check("snap_done", 32'(done), 32'd1);
        fill(0);
        @(negedge clk);

        // reset mid-transfer at word 10
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11 + H) @(negedge clk);
        check("pre_rst_word", m_axis_tdata, expw(10 + H));
        reset = 1'b0;
        #1;
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_busy",   32'(busy), 32'd0);
        check("mid_rst_tlast",  32'(m_axis_tlast), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        recv(0, 100);
        check("rst_restart_done", 32'(done), 32'd1);
        @(negedge clk);

        // start held high through DONE
        start = 1'b1;
        @(negedge clk);
        recv(0, 100);
        check("b2b_done", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_idle_busy",   32'(busy), 32'd0);
        check("b2b_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("b2b_load_busy",   32'(busy), 32'd1);
        check("b2b_load_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk);
        check("b2b_first_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("b2b_first_tdata",  m_axis_tdata, expw(0));
        start = 1'b0;
        recv(0, 100);
        check("b2b_done2", 32'(done), 32'd1);
        @(negedge clk);
        check("b2b_final_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
